rom_burst_reader: RTL and testbench
===================================

Name: rom_burst_reader

Overview:
- Upstream sequencer for the 16x4 synchronous ROM.
- On a start command it walks a burst of consecutive ROM addresses, with wrap-around, and drives the ROM enable and address.
- It captures the ROM's registered data and presents the words on a valid/ready stream to downstream logic.
- A small output FIFO absorbs downstream back-pressure so that no ROM read is ever lost.

Parameters:
- ADDR_W, 4, ROM address width (16 words)
- DATA_W, 4, ROM word width
- FIFO_DEPTH, 4, output buffer entries (power of 2, >= 2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  burst request, sampled only when busy=0
- start_addr  in  ADDR_W  first address of burst
- length  in  ADDR_W+1  words to read; 0 = no-op, values >16 clamp to 16
- rom_enable  out  1  read strobe to ROM (registered)
- rom_address  out  ADDR_W  read address to ROM (registered)
- rom_data  in  DATA_W  ROM data_out, valid the cycle after rom_enable=1
- out_data  out  DATA_W  stream word
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accept
- out_last  out  1  qualifies final word of burst
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (async assert, sync release):
  - rom_enable=0, rom_address=0, out_valid=0, out_last=0, busy=0, done=0.
  - FIFO empty; counters cleared; any in-flight read discarded.
- FSM states:
  - IDLE -> ISSUE when start=1 and clamped length>0.
  - ISSUE -> DRAIN when the last read is issued.
  - DRAIN -> IDLE on handshake of the word with out_last=1; done=1 that cycle+1.
- start while busy=1: ignored. start with length=0: ignored, no done pulse.
- busy=1 from the cycle after start is sampled until the cycle done pulses; busy=0 in the done cycle.
- Issue rule:
  - A read is issued (rom_enable=1 for one cycle, rom_address=current address) only if FIFO occupancy + reads in flight < FIFO_DEPTH, taking into account a pop in the same cycle.
  - The FIFO must never overflow and no rom_data word may be dropped.
- rom_enable=0 in every cycle with no issued read. rom_address holds its last value when idle.
- Address: starts at start_addr, +1 per issued read, modulo 16 (15 wraps to 0).
- Capture: rom_data is written to the FIFO only in the cycle after an issued read. In all other cycles rom_data is ignored.
- Latency: start sampled at edge 0 -> rom_enable=1 in cycle 1 -> word written end of cycle 2 -> out_valid=1 in cycle 3.
- Throughput: with out_ready held 1, one word per cycle, with no bubbles after the first.
- Stream rules:
  - out_data, out_valid and out_last stay stable while out_valid=1 and out_ready=0.
  - Handshake = out_valid & out_ready.
  - out_last=1 only on the length-th word of the burst.
- FIFO simultaneous push and pop on a full FIFO is not reachable by the issue rule. On an empty FIFO, a push appears on the output in the next cycle (no combinational bypass).
- Reset mid-burst: outputs return to reset values immediately; no done pulse; a subsequent start behaves as from fresh reset.

Decomposition:
- Shared package holds:
  - ADDR_W, DATA_W and ROM_WORDS=16 constants.
  - FSM state enum {IDLE, ISSUE, DRAIN}.
  - Length clamp helper constant MAX_LEN=16.
- One sub-module: rom_burst_fifo.
  - Synchronous show-ahead FIFO, parameterised DATA_W+1 wide (data plus last flag) and FIFO_DEPTH deep.
  - Exposes full, empty and count.
  - rom_burst_reader instantiates it; the FSM, address counter and credit counter stay at top level.

Test Plan:
- Reset, then start=1, start_addr=4'hA, length=4, out_ready=1:
  - rom_address 0xA,0xB,0xC,0xD on consecutive cycles; first out_valid 3 cycles after start.
  - Words equal ROM[0xA..0xD]; out_last on 4th word; done pulses once.
- start_addr=4'hE, length=4:
  - Addresses 0xE,0xF,0x0,0x1 (wrap); data matches ROM contents at those addresses.
- length=16, out_ready toggling 1-cycle-on/3-off:
  - Exactly 16 handshakes and no lost or duplicated words.
  - rom_enable never issued while occupancy + in-flight = 4; data stable while stalled.
- length=0 with start=1:
  - busy stays 0, rom_enable stays 0, no done.
- A second start pulse mid-burst (start_addr=0x3):
  - Ignored; the original burst completes unchanged.
- rst asserted 2 cycles after the first rom_enable of a length=8 burst:
  - All outputs go to reset values asynchronously; no done.
  - A new burst start_addr=0, length=2 then returns ROM[0], ROM[1] with correct out_last.

Source files
------------

// File: rtl/rom_burst_reader_pkg.sv
// Shared constants, FSM state type and length clamp for the ROM burst reader.
package rom_burst_reader_pkg;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 4;
  localparam int unsigned ROM_WORDS = 16;
  localparam int unsigned MAX_LEN   = 16;
  localparam int unsigned LEN_W     = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Requested lengths above the ROM size read the whole ROM once.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/rom_burst_fifo.sv
// Show-ahead FIFO buffering captured ROM words (data plus last flag).
module rom_burst_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Burst sequencer for the 16x4 synchronous ROM with a credit-limited output FIFO.
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              rom_enable,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FW    = DATA_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CR_W  = CNT_W + 1;

  state_e            state_q;
  logic              rom_enable_q;
  logic [ADDR_W-1:0] rom_address_q;
  logic              en_last_q;
  logic              cap_q;
  logic              cap_last_q;
  logic [LEN_W-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;

  logic [FW-1:0]     fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              handshake;
  logic [LEN_W-1:0]  len_c;
  logic [CR_W-1:0]   credit_c;
  logic              can_issue_c;

  assign rom_enable  = rom_enable_q;
  assign rom_address = rom_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign out_valid   = ~fifo_empty;
  assign out_data    = fifo_rd[DATA_W-1:0];
  assign out_last    = out_valid & fifo_rd[DATA_W];
  assign handshake   = out_valid & out_ready;
  assign len_c       = clamp_len(length);

  // Occupancy after this edge plus reads still heading for the FIFO.
  assign credit_c    = CR_W'(fifo_count) + CR_W'(cap_q) + CR_W'(rom_enable_q)
                     - CR_W'(handshake);
  assign can_issue_c = (credit_c < CR_W'(FIFO_DEPTH)) & ~fifo_full;

  rom_burst_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (cap_q),
    .push_data_i ({cap_last_q, rom_data}),
    .pop_i       (handshake),
    .pop_data_o  (fifo_rd),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Burst FSM, ROM read issue, capture pipeline and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rom_enable_q  <= 1'b0;
      rom_address_q <= '0;
      en_last_q     <= 1'b0;
      cap_q         <= 1'b0;
      cap_last_q    <= 1'b0;
      rem_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      rom_enable_q <= 1'b0;
      en_last_q    <= 1'b0;
      cap_q        <= rom_enable_q;
      cap_last_q   <= en_last_q;
      case (state_q)
        IDLE: begin
          if (start && (len_c != '0)) begin
            rom_enable_q  <= 1'b1;
            rom_address_q <= start_addr;
            busy_q        <= 1'b1;
            rem_q         <= len_c - LEN_W'(1);
            if (len_c == LEN_W'(1)) begin
              en_last_q <= 1'b1;
              state_q   <= DRAIN;
            end else begin
              state_q   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (can_issue_c) begin
            rom_enable_q  <= 1'b1;
            rom_address_q <= rom_address_q + ADDR_W'(1);
            rem_q         <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              en_last_q <= 1'b1;
              state_q   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (handshake && out_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader with a behavioural ROM and stream model.
module tb_rom_burst_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic       rom_enable;
  logic [3:0] rom_address;
  logic [3:0] rom_data;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mode   = 0;

  logic [3:0] rom_mem [16];
  logic [3:0] exp_addr_q [$];
  logic [4:0] exp_word_q [$];

  int   issued_n = 0;
  int   popped_n = 0;
  int   hs_n     = 0;
  int   done_n   = 0;
  logic prev_stall = 1'b0;
  logic [3:0] prev_data = '0;
  logic prev_last = 1'b0;

  rom_burst_reader #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .rom_enable  (rom_enable),
    .rom_address (rom_address),
    .rom_data    (rom_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous 16x4 ROM: data appears the cycle after enable.
  initial rom_data = '0;
  always @(posedge clk) begin
    if (rom_enable) rom_data <= rom_mem[rom_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: address order, word order, credit bound, stall stability.
  always @(negedge clk) begin
    if (rst) begin
      issued_n   = 0;
      popped_n   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (rom_enable) begin
        issued_n++;
        if (exp_addr_q.size() > 0) chk("rom_address", 32'(rom_address), 32'(exp_addr_q.pop_front()));
        else                       chk("unexpected_issue", 32'(rom_enable), 32'd0);
        chk("outstanding_le_depth", 32'((issued_n - popped_n) <= 4), 32'd1);
      end
      if (out_valid && out_ready) begin
        hs_n++;
        popped_n++;
        if (exp_word_q.size() > 0) chk("word", 32'({out_last, out_data}), 32'(exp_word_q.pop_front()));
        else                       chk("unexpected_word", 32'(out_valid), 32'd0);
      end
      if (done) done_n++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Advance one cycle and drive out_ready according to the current mode.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc % 4) == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_burst(input logic [3:0] a, input logic [4:0] l, input int m, input bit mid_start);
    int n;
    int hs0;
    int d0;
    int done_cyc;
    bit seen;
    logic [3:0] ad;
    n        = (int'(l) > 16) ? 16 : int'(l);
    hs0      = hs_n;
    d0       = done_n;
    done_cyc = 0;
    seen     = 1'b0;
    mode     = m;
    for (int i = 0; i < n; i++) begin
      ad = a + 4'(i);
      exp_addr_q.push_back(ad);
      exp_word_q.push_back({(i == n - 1), rom_mem[ad]});
    end
    start      = 1'b1;
    start_addr = a;
    length     = l;
    tick();
    start      = 1'b0;
    start_addr = 4'($urandom);
    length     = 5'($urandom);
    if (n == 0) begin
      repeat (4) begin
        @(negedge clk);
        chk("noop_busy", 32'(busy), 32'd0);
        chk("noop_enable", 32'(rom_enable), 32'd0);
        chk("noop_done", 32'(done), 32'd0);
        tick();
      end
      chk("noop_done_count", 32'(done_n - d0), 32'd0);
      return;
    end
    @(negedge clk);
    chk("first_enable", 32'(rom_enable), 32'd1);
    chk("busy_after_start", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("valid_cycle2", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("valid_cycle3", 32'(out_valid), 32'd1);
    for (int k = 4; k < 400 && !seen; k++) begin
      tick();
      if (mid_start && k == 5) begin
        start      = 1'b1;
        start_addr = 4'h3;
        length     = 5'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        seen     = 1'b1;
        done_cyc = k;
        chk("busy_in_done_cycle", 32'(busy), 32'd0);
      end else begin
        chk("busy_during_burst", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    if (m == 0) chk("done_cycle_no_bubbles", 32'(done_cyc), 32'(3 + n));
    tick();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("handshake_count", 32'(hs_n - hs0), 32'(n));
    chk("done_count", 32'(done_n - d0), 32'd1);
    chk("words_left", 32'(exp_word_q.size()), 32'd0);
    chk("addrs_left", 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] a;
    int d0;
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", 32'(rom_enable), 32'd0);
    chk("rst_address", 32'(rom_address), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    run_burst(4'hA, 5'd4, 0, 1'b0);
    run_burst(4'hE, 5'd4, 0, 1'b0);
    run_burst(4'($urandom), 5'd16, 1, 1'b0);
    run_burst(4'($urandom), 5'd0, 0, 1'b0);
    run_burst(4'h7, 5'd12, 0, 1'b1);
    run_burst(4'h5, 5'd20, 2, 1'b0);
    run_burst(4'hF, 5'd1, 0, 1'b0);
    repeat (6) run_burst(4'($urandom), 5'($urandom_range(0, 20)), $urandom_range(0, 2), 1'b0);

    // Reset two cycles after the first read of a length-8 burst.
    mode = 0;
    a = 4'($urandom);
    for (int i = 0; i < 8; i++) begin
      exp_addr_q.push_back(a + 4'(i));
      exp_word_q.push_back({(i == 7), rom_mem[a + 4'(i)]});
    end
    start      = 1'b1;
    start_addr = a;
    length     = 5'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    d0  = done_n;
    rst = 1'b1;
    #1;
    chk("mid_rst_enable", 32'(rom_enable), 32'd0);
    chk("mid_rst_address", 32'(rom_address), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    exp_addr_q.delete();
    exp_word_q.delete();
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("held_rst_done", 32'(done), 32'd0);
    end
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_no_done", 32'(done_n - d0), 32'd0);
    run_burst(4'h0, 5'd2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
